// File: rtl/queue_ctrl.sv
// queue_ctrl: sequencing controller for the deserializer -> fila byte path.
// Converts the deserializer's level data_ready into one enqueue pulse plus an ack,
// tracks occupancy, rate-limits dequeue pulses and keeps sticky error flags.
// Every pulse and the occupancy update are decided on the same clock edge from
// pre-update state. This means a push and a pop issued together leave len unchanged.
module queue_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DRAIN_GAP = 4
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             data_ready_in,
  output logic             ack_out,
  output logic             enqueue_out,
  input  logic             dequeue_req_in,
  output logic             dequeue_out,
  output logic [CNT_W-1:0] len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int unsigned      GAP_W    = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DRAIN_GAP - 1);

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_PUSH = 2'd1,
    E_ACK  = 2'd2,
    E_WAIT = 2'd3
  } enq_state_e;

  enq_state_e       state_q, state_d;
  logic             enq_q, enq_d;
  logic             ack_q, ack_d;
  logic             deq_q, deq_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             pend_q, pend_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             req_q, req_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             block_c;
  logic             rise_c;
  logic             issue_c;
  logic             drop_c;

  // Occupancy decode from the registered counter
  always_comb begin
    full_c  = (len_q == LEN_MAX);
    empty_c = (len_q == '0);
  end

  // Enqueue FSM next state; a byte is accepted only when space exists
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    block_c = 1'b0;
    case (state_q)
      E_IDLE: begin
        if (data_ready_in) begin
          if (!full_c) begin
            push_c  = 1'b1;
            state_d = E_PUSH;
          end else begin
            block_c = 1'b1;
          end
        end
      end
      E_PUSH:  state_d = E_ACK;
      E_ACK:   state_d = E_WAIT;
      E_WAIT:  if (!data_ready_in) state_d = E_IDLE;
      default: state_d = E_IDLE;
    endcase
  end

  // Dequeue request edge detection, merge/drop and rate-limited issue
  always_comb begin
    req_d   = dequeue_req_in;
    rise_c  = dequeue_req_in & ~req_q;
    issue_c = pend_q & ~empty_c & (gap_q == '0);
    // An edge seen while empty is dropped unless a push lands on the same edge
    drop_c  = rise_c & empty_c & ~push_c;
    pend_d  = (pend_q & ~issue_c) | (rise_c & ~drop_c);
    if (issue_c) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Output pulses, occupancy and sticky error flags
  always_comb begin
    enq_d = push_c;
    ack_d = (state_q == E_PUSH);
    deq_d = issue_c;
    len_d = len_q;
    case ({push_c, issue_c})
      2'b10:   len_d = len_q + CNT_W'(1);
      2'b01:   len_d = len_q - CNT_W'(1);
      default: len_d = len_q;
    endcase
    ovf_d = ovf_q | block_c;
    unf_d = unf_q | drop_c;
  end

  // State registers with asynchronous clear; reset kills any pulse in flight
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q <= E_IDLE;
      enq_q   <= 1'b0;
      ack_q   <= 1'b0;
      deq_q   <= 1'b0;
      len_q   <= '0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enq_q   <= enq_d;
      ack_q   <= ack_d;
      deq_q   <= deq_d;
      len_q   <= len_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Port mapping
  always_comb begin
    ack_out     = ack_q;
    enqueue_out = enq_q;
    dequeue_out = deq_q;
    len_out     = len_q;
    full_out    = full_c;
    empty_out   = empty_c;
    err_ovf     = ovf_q;
    err_unf     = unf_q;
  end

endmodule
